// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported synchronous RAM between the instruction fetch (IF)
// path and the MEM stage load/store path. Only one access is in flight at a
// time. A request is granted in IDLE through a valid/ready handshake and issued
// to the RAM in the same cycle. The arbiter then waits MEM_LAT cycles and
// returns a one-cycle response pulse to the winner.
//
// MEM normally wins. A starvation counter lets a waiting fetch win after
// STARVE_MAX back-to-back MEM grants.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   if_req_valid/addr/ready          fetch request handshake
//   if_resp_valid/data               fetch response (one-cycle pulse)
//   mem_req_valid/we/addr/wstrb/
//     wdata/ready                    load/store request handshake
//   mem_resp_valid/data              load data / store completion pulse
//   ram_en/we/addr/wdata             RAM command (non-zero only on issue)
//   ram_rdata                        RAM read data, MEM_LAT cycles after ram_en
//   busy                             access outstanding (state WAIT)
//
// MEM_LAT must lie in 1..4. lat_cnt is 3 bits wide and counts from 1 up to
// MEM_LAT.
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_req_ready,
    output logic                  if_resp_valid,
    output logic [DATA_W-1:0]     if_resp_data,

    input  logic                  mem_req_valid,
    input  logic                  mem_req_we,
    input  logic [ADDR_W-1:0]     mem_req_addr,
    input  logic [DATA_W/8-1:0]   mem_req_wstrb,
    input  logic [DATA_W-1:0]     mem_req_wdata,
    output logic                  mem_req_ready,
    output logic                  mem_resp_valid,
    output logic [DATA_W-1:0]     mem_resp_data,

    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,

    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic       OWNER_IF  = 1'b0;
    localparam logic       OWNER_MEM = 1'b1;

    localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT);
    localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    logic [0:0] state_reg,      state_next;
    logic       owner_reg,      owner_next;
    logic       is_write_reg,   is_write_next;
    logic [2:0] lat_cnt_reg,    lat_cnt_next;
    logic [2:0] starve_cnt_reg, starve_cnt_next;

    // -----------------------------------------------------------------------
    // Grant decision (only meaningful in IDLE)
    // -----------------------------------------------------------------------
    logic is_idle;
    logic mem_wins;
    logic if_wins;
    logic issue;
    logic mem_store;
    logic lat_done;

    assign is_idle = (state_reg == ST_IDLE);

    // MEM wins unless the fetch has waited through STARVE_MAX MEM grants.
    assign mem_wins = is_idle && mem_req_valid &&
                      ((starve_cnt_reg < STARVE_LIM) || !if_req_valid);
    assign if_wins  = is_idle && !mem_wins && if_req_valid;

    // A winner always has its valid high, so the grant is also the issue.
    assign issue     = mem_wins || if_wins;
    assign mem_store = mem_wins && mem_req_we;

    assign lat_done  = !is_idle && (lat_cnt_reg == LAT_LAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        is_write_next = is_write_reg;
        lat_cnt_next  = lat_cnt_reg;

        if (is_idle) begin
            if (issue) begin
                state_next    = ST_WAIT;
                lat_cnt_next  = 3'd1;
                owner_next    = mem_wins ? OWNER_MEM : OWNER_IF;
                is_write_next = mem_store;
            end
        end else begin
            if (lat_done) begin
                state_next   = ST_IDLE;
                lat_cnt_next = 3'd0;
            end else begin
                lat_cnt_next = lat_cnt_reg + 3'd1;
            end
        end
    end

    // The starvation count only survives while the fetch keeps its request up.
    // It holds through WAIT cycles and counts MEM grants that skipped the fetch.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!if_req_valid || if_wins) begin
            starve_cnt_next = 3'd0;
        end else if (mem_wins) begin
            if (starve_cnt_reg < STARVE_LIM) begin
                starve_cnt_next = starve_cnt_reg + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWNER_IF;
            is_write_reg   <= 1'b0;
            lat_cnt_reg    <= 3'd0;
            starve_cnt_reg <= 3'd0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            is_write_reg   <= is_write_next;
            lat_cnt_reg    <= lat_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Everything is forced low while rst is high. This also drops a
    // response whose latency expires during reset.
    // -----------------------------------------------------------------------
    logic run;
    assign run = !rst;

    assign if_req_ready  = run && if_wins;
    assign mem_req_ready = run && mem_wins;
    assign busy          = run && !is_idle;

    assign ram_en   = run && issue;
    assign ram_addr = !run     ? '0 :
                      mem_wins ? mem_req_addr :
                      if_wins  ? if_req_addr  : '0;

    // Byte lanes of the write command. They are non-zero only for a MEM store
    // on its issue cycle.
    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign ram_we[gi]              = run && mem_store && mem_req_wstrb[gi];
            assign ram_wdata[gi*8 +: 8]    = (run && mem_store) ? mem_req_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // The response goes only to the owner. Stores return zero data.
    assign if_resp_valid  = run && lat_done && (owner_reg == OWNER_IF);
    assign mem_resp_valid = run && lat_done && (owner_reg == OWNER_MEM);

    assign if_resp_data   = if_resp_valid ? ram_rdata : '0;
    assign mem_resp_data  = (mem_resp_valid && !is_write_reg) ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_port_arbiter.
//
// Two instances share all request inputs and the reset: dut_a has MEM_LAT=1
// and dut_b has MEM_LAT=3. Each instance has its own small RAM read model.
// Every scenario starts from a reset. Each scenario task checks only the
// instance it targets.
//
// Inputs change 1 ns after a rising edge. Outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wstrb;
    logic [31:0] mem_req_wdata;

    // Outputs of dut_a (MEM_LAT=1).
    logic        a_if_req_ready, a_if_resp_valid, a_mem_req_ready, a_mem_resp_valid;
    logic [31:0] a_if_resp_data, a_mem_resp_data, a_ram_addr, a_ram_wdata, a_ram_rdata;
    logic        a_ram_en, a_busy;
    logic [3:0]  a_ram_we;

    // Outputs of dut_b (MEM_LAT=3).
    logic        b_if_req_ready, b_if_resp_valid, b_mem_req_ready, b_mem_resp_valid;
    logic [31:0] b_if_resp_data, b_mem_resp_data, b_ram_addr, b_ram_wdata, b_ram_rdata;
    logic        b_ram_en, b_busy;
    logic [3:0]  b_ram_we;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(a_if_req_ready),
        .if_resp_valid(a_if_resp_valid), .if_resp_data(a_if_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata), .mem_req_ready(a_mem_req_ready),
        .mem_resp_valid(a_mem_resp_valid), .mem_resp_data(a_mem_resp_data),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata),
        .ram_rdata(a_ram_rdata), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(b_if_req_ready),
        .if_resp_valid(b_if_resp_valid), .if_resp_data(b_if_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata), .mem_req_ready(b_mem_req_ready),
        .mem_resp_valid(b_mem_resp_valid), .mem_resp_data(b_mem_resp_data),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    // RAM contents as seen by reads. A few fixed words are derived from the address.
    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        if (addr == 32'h100) return 32'hDEADBEEF;
        return {addr[15:0], 16'hC0DE};
    endfunction

    // Read pipelines. The data appears MEM_LAT cycles after ram_en and is 0 otherwise.
    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        a_pipe    <= a_ram_en ? ram_word(a_ram_addr) : 32'h0;
        b_pipe[0] <= b_ram_en ? ram_word(b_ram_addr) : 32'h0;
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_ram_rdata = a_pipe;
    assign b_ram_rdata = b_pipe[2];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req_valid  = 1'b0;
        if_req_addr   = 32'h0;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_wstrb = 4'h0;
        mem_req_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        // Requests raised during reset must not be granted.
        if_req_valid  = 1'b1; if_req_addr = 32'h100;
        mem_req_valid = 1'b1; mem_req_addr = 32'h20;
        @(negedge clk);
        chk_cnt++; if ({a_if_req_ready, a_mem_req_ready, a_ram_en, a_busy} !== 4'b0)
            $display("FAIL rst_ready_a: got %b want 0000", {a_if_req_ready, a_mem_req_ready, a_ram_en, a_busy}); else pass_cnt++;
        chk_cnt++; if ({b_if_req_ready, b_mem_req_ready, b_ram_en, b_busy} !== 4'b0)
            $display("FAIL rst_ready_b: got %b want 0000", {b_if_req_ready, b_mem_req_ready, b_ram_en, b_busy}); else pass_cnt++;
        chk_cnt++; if (a_ram_addr !== 32'h0)
            $display("FAIL rst_ram_addr: got %h want 0", a_ram_addr); else pass_cnt++;
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({a_busy, a_ram_en, a_if_resp_valid, a_mem_resp_valid} !== 4'b0)
            $display("FAIL post_rst_idle: got %b want 0000", {a_busy, a_ram_en, a_if_resp_valid, a_mem_resp_valid}); else pass_cnt++;
        $display("test_reset done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_if_read();
        do_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h100;
        @(negedge clk);  // cycle T
        chk_cnt++; if (a_if_req_ready !== 1'b1) $display("FAIL ifrd_ready_T: got %b want 1", a_if_req_ready); else pass_cnt++;
        chk_cnt++; if (a_ram_en !== 1'b1 || a_ram_addr !== 32'h100 || a_ram_we !== 4'h0)
            $display("FAIL ifrd_issue: got en=%b addr=%h we=%h want 1/100/0", a_ram_en, a_ram_addr, a_ram_we); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b0) $display("FAIL ifrd_busy_T: got %b want 0", a_busy); else pass_cnt++;
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);  // T+1
        chk_cnt++; if (a_if_resp_valid !== 1'b1 || a_if_resp_data !== 32'hDEADBEEF)
            $display("FAIL ifrd_resp: got v=%b d=%h want 1/deadbeef", a_if_resp_valid, a_if_resp_data); else pass_cnt++;
        chk_cnt++; if (a_busy !== 1'b1 || a_mem_resp_valid !== 1'b0 || a_if_req_ready !== 1'b0)
            $display("FAIL ifrd_wait: got busy=%b mresp=%b rdy=%b want 1/0/0", a_busy, a_mem_resp_valid, a_if_req_ready); else pass_cnt++;
        next_cycle();
        @(negedge clk);  // T+2
        chk_cnt++; if (a_busy !== 1'b0 || a_if_resp_valid !== 1'b0)
            $display("FAIL ifrd_done: got busy=%b resp=%b want 0/0", a_busy, a_if_resp_valid); else pass_cnt++;
        $display("test_if_read done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous();
        do_reset();
        if_req_valid  = 1'b1; if_req_addr = 32'h200;
        mem_req_valid = 1'b1; mem_req_we = 1'b1; mem_req_addr = 32'h20;
        mem_req_wstrb = 4'h3; mem_req_wdata = 32'h1234;
        @(negedge clk);  // T
        chk_cnt++; if (a_mem_req_ready !== 1'b1 || a_if_req_ready !== 1'b0)
            $display("FAIL sim_grant: got mrdy=%b irdy=%b want 1/0", a_mem_req_ready, a_if_req_ready); else pass_cnt++;
        chk_cnt++; if (a_ram_we !== 4'h3 || a_ram_addr !== 32'h20 || a_ram_wdata !== 32'h1234)
            $display("FAIL sim_store_cmd: got we=%h addr=%h wd=%h want 3/20/1234", a_ram_we, a_ram_addr, a_ram_wdata); else pass_cnt++;
        next_cycle();
        mem_req_valid = 1'b0; mem_req_we = 1'b0; mem_req_wstrb = 4'h0; mem_req_wdata = 32'h0;
        @(negedge clk);  // T+1
        chk_cnt++; if (a_mem_resp_valid !== 1'b1 || a_mem_resp_data !== 32'h0 || a_if_resp_valid !== 1'b0)
            $display("FAIL sim_store_resp: got v=%b d=%h ir=%b want 1/0/0", a_mem_resp_valid, a_mem_resp_data, a_if_resp_valid); else pass_cnt++;
        chk_cnt++; if (a_if_req_ready !== 1'b0) $display("FAIL sim_if_wait: got %b want 0", a_if_req_ready); else pass_cnt++;
        next_cycle();
        @(negedge clk);  // T+2
        chk_cnt++; if (a_if_req_ready !== 1'b1 || a_ram_addr !== 32'h200 || a_ram_we !== 4'h0 || a_ram_wdata !== 32'h0)
            $display("FAIL sim_if_issue: got rdy=%b addr=%h we=%h wd=%h want 1/200/0/0", a_if_req_ready, a_ram_addr, a_ram_we, a_ram_wdata); else pass_cnt++;
        next_cycle();
        if_req_valid = 1'b0;
        @(negedge clk);  // T+3
        chk_cnt++; if (a_if_resp_valid !== 1'b1 || a_if_resp_data !== 32'h0200C0DE)
            $display("FAIL sim_if_resp: got v=%b d=%h want 1/0200c0de", a_if_resp_valid, a_if_resp_data); else pass_cnt++;
        $display("test_simultaneous done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_starvation();
        logic exp_if;
        do_reset();
        if_req_valid  = 1'b1; if_req_addr  = 32'h180;
        mem_req_valid = 1'b1; mem_req_addr = 32'h80;
        // Expected grant order: M M M M I M M M M I. The second run shows the
        // counter restarted from zero after the fetch grant.
        for (int g = 0; g < 10; g++) begin
            exp_if = (g == 4) || (g == 9);
            @(negedge clk);
            chk_cnt++; if (a_if_req_ready !== exp_if || a_mem_req_ready !== !exp_if)
                $display("FAIL starve_grant_%0d: got irdy=%b mrdy=%b want %b/%b", g, a_if_req_ready, a_mem_req_ready, exp_if, !exp_if); else pass_cnt++;
            next_cycle();
            next_cycle();
        end
        clear_inputs();
        $display("test_starvation done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic        exp_rdy, exp_resp, exp_busy;
        logic [31:0] exp_data;
        do_reset();
        mem_req_valid = 1'b1; mem_req_addr = 32'h40;
        for (int c = 0; c <= 8; c++) begin
            if (c == 4) mem_req_addr = 32'h44;
            exp_rdy  = (c == 0) || (c == 4) || (c == 8);
            exp_resp = (c == 3) || (c == 7);
            exp_busy = !exp_rdy;
            exp_data = (c == 3) ? 32'h0040C0DE : (c == 7) ? 32'h0044C0DE : 32'h0;
            @(negedge clk);
            chk_cnt++; if (b_mem_req_ready !== exp_rdy || b_ram_en !== exp_rdy || b_busy !== exp_busy)
                $display("FAIL b2b_ctl_%0d: got rdy=%b en=%b busy=%b want %b/%b/%b", c, b_mem_req_ready, b_ram_en, b_busy, exp_rdy, exp_rdy, exp_busy); else pass_cnt++;
            chk_cnt++; if (b_mem_resp_valid !== exp_resp || b_mem_resp_data !== exp_data)
                $display("FAIL b2b_resp_%0d: got v=%b d=%h want %b/%h", c, b_mem_resp_valid, b_mem_resp_data, exp_resp, exp_data); else pass_cnt++;
            next_cycle();
        end
        clear_inputs();
        $display("test_back_to_back done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_wait();
        do_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h300;
        @(negedge clk);  // T
        chk_cnt++; if (b_if_req_ready !== 1'b1) $display("FAIL rmw_issue: got %b want 1", b_if_req_ready); else pass_cnt++;
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();    // T+2, second WAIT cycle
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++; if ({b_if_resp_valid, b_busy, b_ram_en, b_if_req_ready} !== 4'b0)
            $display("FAIL rmw_in_rst: got %b want 0000", {b_if_resp_valid, b_busy, b_ram_en, b_if_req_ready}); else pass_cnt++;
        next_cycle();    // T+3, the abandoned read data is on ram_rdata
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++; if ({b_if_resp_valid, b_mem_resp_valid, b_busy, b_ram_en} !== 4'b0 || b_if_resp_data !== 32'h0)
            $display("FAIL rmw_after: got %b d=%h want 0000/0", {b_if_resp_valid, b_mem_resp_valid, b_busy, b_ram_en}, b_if_resp_data); else pass_cnt++;
        next_cycle();    // T+4
        if_req_valid = 1'b1; if_req_addr = 32'h304;
        @(negedge clk);
        chk_cnt++; if (b_if_req_ready !== 1'b1 || b_ram_addr !== 32'h304)
            $display("FAIL rmw_new_req: got rdy=%b addr=%h want 1/304", b_if_req_ready, b_ram_addr); else pass_cnt++;
        next_cycle();
        if_req_valid = 1'b0;
        next_cycle();
        next_cycle();    // T+7
        @(negedge clk);
        chk_cnt++; if (b_if_resp_valid !== 1'b1 || b_if_resp_data !== 32'h0304C0DE)
            $display("FAIL rmw_new_resp: got v=%b d=%h want 1/0304c0de", b_if_resp_valid, b_if_resp_data); else pass_cnt++;
        $display("test_reset_mid_wait done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_withdraw();
        do_reset();
        if_req_valid = 1'b1; if_req_addr = 32'h400;
        @(negedge clk);  // T: IF alone wins
        chk_cnt++; if (a_if_req_ready !== 1'b1) $display("FAIL wd_if_grant: got %b want 1", a_if_req_ready); else pass_cnt++;
        next_cycle();    // T+1: WAIT, MEM raises valid
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b1; mem_req_addr = 32'h500;
        @(negedge clk);
        chk_cnt++; if (a_mem_req_ready !== 1'b0 || a_ram_en !== 1'b0)
            $display("FAIL wd_wait_block: got rdy=%b en=%b want 0/0", a_mem_req_ready, a_ram_en); else pass_cnt++;
        next_cycle();    // T+2: MEM withdraws before being granted
        mem_req_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_cnt++; if (a_ram_en !== 1'b0 || a_mem_req_ready !== 1'b0 || a_mem_resp_valid !== 1'b0)
                $display("FAIL wd_idle_%0d: got en=%b rdy=%b resp=%b want 0/0/0", c, a_ram_en, a_mem_req_ready, a_mem_resp_valid); else pass_cnt++;
            next_cycle();
        end
        mem_req_valid = 1'b1; mem_req_addr = 32'h500;  // T+4
        @(negedge clk);
        chk_cnt++; if (a_mem_req_ready !== 1'b1 || a_ram_en !== 1'b1 || a_ram_addr !== 32'h500)
            $display("FAIL wd_reissue: got rdy=%b en=%b addr=%h want 1/1/500", a_mem_req_ready, a_ram_en, a_ram_addr); else pass_cnt++;
        next_cycle();
        mem_req_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if (a_mem_resp_valid !== 1'b1 || a_mem_resp_data !== 32'h0500C0DE)
            $display("FAIL wd_resp: got v=%b d=%h want 1/0500c0de", a_mem_resp_valid, a_mem_resp_data); else pass_cnt++;
        $display("test_withdraw done");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_if_read();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_mid_wait();
        test_withdraw();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
